// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// next-PC source encodings, controller state encoding and the
// load-use hazard detection helper.
package cpu_pkg;

    // Next-PC source select driven onto the PC mux
    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pc_sel_e;

    // Controller state: normal flow or holding for a multi-cycle MDU op
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } hz_state_e;

    // A load in EX whose destination feeds the instruction in ID.
    // $zero is never a real dependency, so it never stalls.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Holds at all-ones once reached; synchronous clear has priority.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Count up on inc, stop at all-ones, zero on clear
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Drives PC / IF/ID / ID/EX write enables and the IF/ID, ID/EX, EX/MEM
// bubble inserts, selects the next-PC source, and sequences MDU waits.
// Control outputs are combinational from state and inputs; state,
// wait counter, sticky timeout flag and performance counters are registered.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_Branch,
    input  logic             mem_zero,
    input  logic             mem_Jump,
    input  logic             mem_jr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       pc_sel,
    output logic             mdu_busy,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

    hz_state_e         state_r;
    hz_state_e         state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_next_s;
    logic              timeout_r;
    logic              timeout_set_s;

    logic              redirect_s;
    logic              load_use_s;
    logic              flush_inc_s;
    logic              stall_inc_s;

    logic              pc_write_s;
    logic              ifid_write_s;
    logic              idex_write_s;
    logic              ifid_flush_s;
    logic              idex_flush_s;
    logic              exmem_flush_s;
    pc_sel_e           pc_sel_s;
    logic              mdu_busy_s;

    assign redirect_s = (mem_Branch & mem_zero) | mem_Jump | mem_jr;
    assign load_use_s = load_use_hit(ex_MemRead, ex_rt, id_rs, id_rt, id_uses_rt);

    // Next-state and control decode; defaults first, reset forces a frozen, bubbled pipe
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        idex_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        pc_sel_s      = PC_SEQ;
        mdu_busy_s    = 1'b0;
        state_next_s  = state_r;
        wait_next_s   = wait_cnt_r;
        timeout_set_s = 1'b0;
        flush_inc_s   = 1'b0;

        if (rst) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            state_next_s  = ST_RUN;
            wait_next_s   = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (redirect_s) begin
                        // Squashes IF/ID/EX, so an MDU start or load-use there is moot
                        if (mem_jr) begin
                            pc_sel_s = PC_JR;
                        end else if (mem_Jump) begin
                            pc_sel_s = PC_J;
                        end else begin
                            pc_sel_s = PC_BR;
                        end
                        ifid_flush_s  = 1'b1;
                        idex_flush_s  = 1'b1;
                        exmem_flush_s = 1'b1;
                        flush_inc_s   = 1'b1;
                    end else if (ex_mdu_start) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_write_s  = 1'b0;
                        exmem_flush_s = 1'b1;
                        state_next_s  = ST_MDU_WAIT;
                        wait_next_s   = '0;
                    end else if (load_use_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_flush_s  = 1'b1;
                    end else begin
                        state_next_s  = ST_RUN;
                    end
                end
                ST_MDU_WAIT: begin
                    mdu_busy_s = 1'b1;
                    if (mdu_done) begin
                        // Result ready: release the pipe, done beats a same-cycle timeout
                        state_next_s = ST_RUN;
                    end else begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_write_s  = 1'b0;
                        exmem_flush_s = 1'b1;
                        wait_next_s   = wait_cnt_r + WAIT_W'(1);
                        if (wait_cnt_r == WAIT_LAST) begin
                            timeout_set_s = 1'b1;
                            state_next_s  = ST_RUN;
                        end else begin
                            state_next_s  = ST_MDU_WAIT;
                        end
                    end
                end
                default: begin
                    state_next_s = ST_RUN;
                    wait_next_s  = '0;
                end
            endcase
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_next_s;
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign stall_inc_s = ~rst & ~pc_write_s;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

    assign pc_write    = pc_write_s;
    assign ifid_write  = ifid_write_s;
    assign idex_write  = idex_write_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_flush  = idex_flush_s;
    assign exmem_flush = exmem_flush_s;
    assign pc_sel      = pc_sel_s;
    assign mdu_busy    = mdu_busy_s;
    assign mdu_timeout = timeout_r;

endmodule
